// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_cmd_parser                                           |
// | Brief    : Decodes ASCII "W<aa><dd>" / "R<aa>" commands popped from  |
// |            a UART RX FIFO, drives an 8-bit register bus and pushes   |
// |            "OK", "<hh>" or "ER" responses (CR LF terminated) into    |
// |            the UART TX FIFO.                                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TO_W           = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_fifo_data,
  input  logic       rx_fifo_empty,
  output logic       rx_fifo_pop,
  output logic [7:0] tx_fifo_data,
  output logic       tx_fifo_push,
  input  logic       tx_fifo_full,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_TERM    = 3'd3,
    S_FLUSH   = 3'd4,
    S_EXEC    = 3'd5,
    S_RD_WAIT = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  localparam logic [7:0]      c_CR      = 8'h0D;
  localparam logic [7:0]      c_LF      = 8'h0A;
  localparam logic [7:0]      c_SP      = 8'h20;
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // True for ASCII 0-9, A-F, a-f
  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Nibble value of a hex character; letters of either case share the low nibble
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  // Uppercase ASCII for a nibble
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  state_t          r_state;
  logic            r_is_wr;
  logic            r_nib;
  logic [7:0]      r_addr_sh;
  logic [7:0]      r_data_sh;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_buf [0:3];
  logic [1:0]      r_idx;
  logic [7:0]      r_reg_addr;
  logic [7:0]      r_reg_wdata;
  logic            r_reg_we;
  logic            r_reg_re;
  logic            r_cmd_err;

  logic            w_receiving;
  logic            w_take;
  logic            w_push;
  logic            w_timed;
  logic            w_to_hit;
  logic            w_is_term;
  logic [7:0]      w_byte;

  // Pop and push are decoded from registered state so that the byte is
  // consumed in the same cycle it is sampled and no push can slip past a
  // full TX FIFO; reset suppresses both immediately.
  always_comb begin
    w_byte      = rx_fifo_data;
    w_is_term   = (w_byte == c_CR) || (w_byte == c_LF);
    w_receiving = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA) ||
                  (r_state == S_TERM) || (r_state == S_FLUSH);
    w_timed     = (r_state == S_ADDR) || (r_state == S_DATA) ||
                  (r_state == S_TERM) || (r_state == S_FLUSH);
    w_take      = w_receiving && !rx_fifo_empty && !rst;
    w_push      = (r_state == S_RESP) && !tx_fifo_full && !rst;
    w_to_hit    = (r_to_cnt == c_TO_LAST);
  end

  assign rx_fifo_pop  = w_take;
  assign tx_fifo_push = w_push;
  assign tx_fifo_data = w_push ? r_buf[r_idx] : 8'h00;
  assign reg_addr     = r_reg_addr;
  assign reg_wdata    = r_reg_wdata;
  assign reg_we       = r_reg_we;
  assign reg_re       = r_reg_re;
  assign cmd_err      = r_cmd_err;
  assign busy         = (r_state != S_IDLE);

  // Inter-byte timeout: counts idle cycles inside a partial command only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (!w_timed || w_take || w_to_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Command parser, bus strobes and response sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_nib       <= 1'b0;
      r_addr_sh   <= 8'h00;
      r_data_sh   <= 8'h00;
      r_idx       <= 2'd0;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_cmd_err   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      r_reg_we  <= 1'b0;
      r_reg_re  <= 1'b0;
      r_cmd_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_nib <= 1'b0;
            if ((w_byte == 8'h57) || (w_byte == 8'h77)) begin
              r_is_wr <= 1'b1;
              r_state <= S_ADDR;
            end else if ((w_byte == 8'h52) || (w_byte == 8'h72)) begin
              r_is_wr <= 1'b0;
              r_state <= S_ADDR;
            end else if (w_is_term || (w_byte == c_SP)) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end

        S_ADDR: begin
          if (w_take) begin
            if (is_hex(w_byte)) begin
              r_addr_sh <= {r_addr_sh[3:0], hex_val(w_byte)};
              r_nib     <= ~r_nib;
              if (r_nib) begin
                r_state <= r_is_wr ? S_DATA : S_TERM;
              end
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end

        S_DATA: begin
          if (w_take) begin
            if (is_hex(w_byte)) begin
              r_data_sh <= {r_data_sh[3:0], hex_val(w_byte)};
              r_nib     <= ~r_nib;
              if (r_nib) begin
                r_state <= S_TERM;
              end
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end

        S_TERM: begin
          if (w_take) begin
            if (w_is_term) begin
              // Bus outputs change only here, together with the strobe,
              // so the strobe is visible during EXEC.
              r_reg_addr <= r_addr_sh;
              if (r_is_wr) begin
                r_reg_wdata <= r_data_sh;
                r_reg_we    <= 1'b1;
              end else begin
                r_reg_re    <= 1'b1;
              end
              r_state <= S_EXEC;
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          if (w_take && w_is_term) begin
            r_buf[0]  <= 8'h45;
            r_buf[1]  <= 8'h52;
            r_buf[2]  <= c_CR;
            r_buf[3]  <= c_LF;
            r_idx     <= 2'd0;
            r_cmd_err <= 1'b1;
            r_state   <= S_RESP;
          end
        end

        S_EXEC: begin
          if (r_is_wr) begin
            r_buf[0] <= 8'h4F;
            r_buf[1] <= 8'h4B;
            r_buf[2] <= c_CR;
            r_buf[3] <= c_LF;
            r_idx    <= 2'd0;
            r_state  <= S_RESP;
          end else begin
            r_state  <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          r_buf[0] <= hex_char(reg_rdata[7:4]);
          r_buf[1] <= hex_char(reg_rdata[3:0]);
          r_buf[2] <= c_CR;
          r_buf[3] <= c_LF;
          r_idx    <= 2'd0;
          r_state  <= S_RESP;
        end

        S_RESP: begin
          if (w_push) begin
            if (r_idx == 2'd3) begin
              r_idx   <= 2'd0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // A stalled partial command is dropped silently
      if (w_timed && !w_take && w_to_hit) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_cmd_parser                                        |
// | Brief    : Scoreboard testbench for uart_cmd_parser                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_cmd_parser;

  logic       clk;
  logic       rst;
  logic [7:0] rx_fifo_data;
  logic       rx_fifo_empty;
  logic       rx_fifo_pop;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_push;
  logic       tx_fifo_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       cmd_err;

  int total = 0;
  int bad   = 0;
  int push_cnt = 0;

  logic [7:0]  rx_q [$];
  logic [7:0]  exp_tx [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  int          exp_err = 0;
  logic [7:0]  rd_val = 8'h00;
  logic        pop_seen = 1'b0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(16), .TO_W(27)) dut (
    .clk(clk), .rst(rst),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_empty(rx_fifo_empty), .rx_fifo_pop(rx_fifo_pop),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_push(tx_fifo_push), .tx_fifo_full(tx_fifo_full),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX FIFO model: show-ahead head, popped after a sampled pop
  always @(negedge clk) pop_seen = rx_fifo_pop;
  always @(posedge clk) begin
    #1;
    if (pop_seen && (rx_q.size() > 0)) void'(rx_q.pop_front());
    rx_fifo_empty = (rx_q.size() == 0);
    rx_fifo_data  = rx_fifo_empty ? 8'h00 : rx_q[0];
  end

  // Register read model: data valid only in the cycle after reg_re
  always @(negedge clk) begin
    if (reg_re) begin
      @(posedge clk);
      #1 reg_rdata = rd_val;
      @(posedge clk);
      #1 reg_rdata = 8'hEE;
    end
  end

  // Monitor: pops expected items whenever the DUT presents an output
  always @(negedge clk) begin : mon
    logic [7:0]  e8;
    logic [15:0] e16;
    if (tx_fifo_push) begin
      push_cnt++;
      chk("push_while_full", tx_fifo_full, 0);
      if (exp_tx.size() == 0) chk("tx_unexpected", 64'(exp_tx.size()), 1);
      else begin
        e8 = exp_tx.pop_front();
        chk("tx_byte", tx_fifo_data, e8);
      end
    end
    if (reg_we) begin
      if (exp_wr.size() == 0) chk("we_unexpected", 64'(exp_wr.size()), 1);
      else begin
        e16 = exp_wr.pop_front();
        chk("reg_write", {reg_addr, reg_wdata}, e16);
      end
    end
    if (reg_re) begin
      if (exp_rd.size() == 0) chk("re_unexpected", 64'(exp_rd.size()), 1);
      else begin
        e8 = exp_rd.pop_front();
        chk("reg_read_addr", reg_addr, e8);
      end
    end
    if (cmd_err) begin
      chk("cmd_err_expected", 64'(exp_err > 0), 1);
      if (exp_err > 0) exp_err--;
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  task automatic exp_resp(input logic [7:0] a, input logic [7:0] b);
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if ((rx_q.size() == 0) && !busy && (exp_tx.size() == 0)) done = 1'b1;
    end
    chk(name, done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pushes(input int target, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (push_cnt >= target) ok = 1'b1;
    end
  endtask

  initial begin : stim
    logic ok;
    int   start;
    int   pops;
    rst = 1'b1;
    tx_fifo_full = 1'b0;
    reg_rdata = 8'hEE;
    rx_fifo_empty = 1'b1;
    rx_fifo_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("outs_in_reset", {rx_fifo_pop, tx_fifo_push, tx_fifo_data, reg_addr, reg_wdata,
                          reg_we, reg_re, busy, cmd_err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("outs_after_reset", {rx_fifo_pop, tx_fifo_push, tx_fifo_data, reg_addr, reg_wdata,
                             reg_we, reg_re, busy, cmd_err}, 0);

    // Plain write
    exp_wr.push_back(16'h3A5C);
    exp_resp(8'h4F, 8'h4B);
    send("W3A5C\r");
    wait_idle("idle_after_write");

    // Lowercase read with LF terminator
    rd_val = 8'hB7;
    exp_rd.push_back(8'h3A);
    exp_resp(8'h42, 8'h37);
    send("r3a\n");
    wait_idle("idle_after_read");

    // Bad hex digit then a normal read
    exp_err++;
    exp_resp(8'h45, 8'h52);
    send("W3G12\r");
    wait_idle("idle_after_err");
    chk("err_consumed", 64'(exp_err), 0);
    rd_val = 8'h4E;
    exp_rd.push_back(8'h00);
    exp_resp(8'h34, 8'h45);
    send("R00\r");
    wait_idle("idle_after_r00");

    // TX backpressure during "OK", with the next command waiting in RX
    start = push_cnt;
    exp_wr.push_back(16'h1234);
    exp_resp(8'h4F, 8'h4B);
    send("W1234\r\n");
    wait_pushes(start + 1, ok);
    chk("first_push_seen", ok, 1);
    #1 tx_fifo_full = 1'b1;
    rd_val = 8'hA5;
    exp_rd.push_back(8'h7F);
    exp_resp(8'h41, 8'h35);
    send("R7F\r");
    pops = 0;
    repeat (10) begin
      @(negedge clk);
      if (rx_fifo_pop) pops++;
    end
    chk("pop_during_hold", 64'(pops), 0);
    chk("pushes_during_hold", 64'(push_cnt - start), 1);
    @(posedge clk); #1 tx_fifo_full = 1'b0;
    wait_idle("idle_after_backpressure");

    // Inter-byte timeout drops a partial command silently
    start = push_cnt;
    send("W1");
    wait_idle("rx_drained_partial");
    repeat (20) @(negedge clk);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_tx", 64'(push_cnt - start), 0);
    rd_val = 8'h3C;
    exp_rd.push_back(8'h05);
    exp_resp(8'h33, 8'h43);
    send("R05\r");
    wait_idle("idle_after_timeout_read");

    // Reset in the middle of a response
    start = push_cnt;
    exp_wr.push_back(16'h0102);
    exp_resp(8'h4F, 8'h4B);
    send("W0102\r");
    wait_pushes(start + 2, ok);
    chk("two_pushes_seen", ok, 1);
    #1 rst = 1'b1;
    exp_tx.delete();
    @(negedge clk);
    chk("push_in_reset", tx_fifo_push, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("outs_after_mid_reset", {rx_fifo_pop, tx_fifo_push, tx_fifo_data, reg_addr, reg_wdata,
                                 reg_we, reg_re, busy, cmd_err}, 0);
    chk("pushes_before_reset", 64'(push_cnt - start), 2);
    exp_wr.push_back(16'h0001);
    exp_resp(8'h4F, 8'h4B);
    send("W0001\r");
    wait_idle("idle_after_reset_write");

    chk("leftover_tx", 64'(exp_tx.size()), 0);
    chk("leftover_wr", 64'(exp_wr.size()), 0);
    chk("leftover_rd", 64'(exp_rd.size()), 0);
    chk("leftover_err", 64'(exp_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
